// File: rtl/demux_rr.sv
// Round-robin 1:2 demultiplexer: splits one word stream into two lanes, each
// buffered by a small FIFO with ready/valid backpressure.
module demux_rr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic [WIDTH-1:0] data_1,
    output logic             valid_1,
    input  logic             ready_1,
    output logic             lane_sel
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    lane_t state, state_next;

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [CNT_W-1:0] count  [2];

    logic       accept;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] lane_valid;
    logic [1:0] lane_full;
    logic [1:0] lane_ready;

    // Per-lane occupancy flags and handshakes
    always_comb begin
        lane_valid = '0;
        lane_full  = '0;
        for (int i = 0; i < 2; i++) begin
            lane_valid[i] = (count[i] != '0);
            lane_full[i]  = (count[i] == CNT_W'(DEPTH));
        end
        lane_ready = {ready_1, ready_0};
        pop        = lane_valid & lane_ready;
        accept     = valid_in && ready_in;
        push       = '0;
        if (accept) begin
            push[lane_sel] = 1'b1;
        end
    end

    // Lane pointer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LANE0;
        end else begin
            state <= state_next;
        end
    end

    // Lane pointer advances only on an accepted word
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = (state == LANE0) ? LANE1 : LANE0;
        end
    end

    // Lane pointer outputs; ready_in sees only registered state
    always_comb begin
        lane_sel = (state == LANE1);
        ready_in = !lane_full[lane_sel];
    end

    // FIFO pointers and counts
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage needs no reset; occupancy gates what is visible
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset && push[i]) begin
                mem[i][wr_ptr[i]] <= data_in;
            end
        end
    end

    assign valid_0 = lane_valid[0];
    assign valid_1 = lane_valid[1];
    assign data_0  = lane_valid[0] ? mem[0][rd_ptr[0]] : '0;
    assign data_1  = lane_valid[1] ? mem[1][rd_ptr[1]] : '0;

endmodule
